// File: rtl/comparator_3bit.sv
// Registered, cascadable unsigned magnitude comparator.
// Produces one-hot lt/eq/gt one clock after a valid input; the cascade
// inputs l/e/g break ties when A equals B so stages can be chained.
module comparator_3bit #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  input  logic             in_valid,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             out_valid
);

  logic lt_next;
  logic eq_next;
  logic gt_next;

  // Next verdict: operand magnitude wins; on a tie, e > l > g priority,
  // and an all-zero cascade resolves to equal so the result stays one-hot.
  always_comb begin
    lt_next = 1'b0;
    eq_next = 1'b0;
    gt_next = 1'b0;
    if (A > B) begin
      gt_next = 1'b1;
    end else if (A < B) begin
      lt_next = 1'b1;
    end else if (e) begin
      eq_next = 1'b1;
    end else if (l) begin
      lt_next = 1'b1;
    end else if (g) begin
      gt_next = 1'b1;
    end else begin
      eq_next = 1'b1;
    end
  end

  // Result register: reset clears everything, valid input loads, otherwise hold flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      lt        <= lt_next;
      eq        <= eq_next;
      gt        <= gt_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comparator_3bit.sv
// Self-checking bench for comparator_3bit: directed cases then random stimulus,
// compared each cycle against a behavioural model of the compare rules.
module tb_comparator_3bit;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             l;
  logic             e;
  logic             g;
  logic             in_valid;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             out_valid;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // model state: expected {lt,eq,gt} and out_valid
  logic [2:0] m_flags = 3'b000;
  logic       m_valid = 1'b0;

  comparator_3bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .l         (l),
    .e         (e),
    .g         (g),
    .in_valid  (in_valid),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Verdict from the rules: integer magnitude, then cascade priority e, l, g.
  function automatic logic [2:0] verdict(input int unsigned a, input int unsigned b,
                                         input bit cl, input bit ce, input bit cg);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    if (ce)    return 3'b010;
    if (cl)    return 3'b100;
    if (cg)    return 3'b001;
    return 3'b010;
  endfunction

  // Drive one cycle, advance the model, and compare after the edge.
  task automatic step(input string tag, input int unsigned a, input int unsigned b,
                      input bit cl, input bit ce, input bit cg,
                      input bit v, input bit r);
    @(negedge clk);
    A        = a[WIDTH-1:0];
    B        = b[WIDTH-1:0];
    l        = cl;
    e        = ce;
    g        = cg;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_flags = 3'b000;
      m_valid = 1'b0;
    end else if (v) begin
      m_flags = verdict(a % (1 << WIDTH), b % (1 << WIDTH), cl, ce, cg);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    check({tag, ".flags"}, {29'd0, lt, eq, gt}, {29'd0, m_flags});
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid)
      check({tag, ".onehot"}, $countones({lt, eq, gt}), 1);
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; l = 1'b0; e = 1'b1; g = 1'b0; in_valid = 1'b0;

    // reset with a valid input present: discarded
    step("rst0", 2, 1, 0, 1, 0, 1, 1);
    step("rst1", 2, 1, 0, 1, 0, 1, 1);
    check("rst_lt", {31'd0, lt}, 32'd0);
    step("first", 2, 1, 0, 1, 0, 1, 0);
    check("first_gt", {31'd0, gt}, 32'd1);

    // equal operands resolved by cascade
    step("eq_e", 1, 1, 0, 1, 0, 1, 0);
    step("eq_l", 1, 1, 1, 0, 0, 1, 0);
    step("eq_g", 1, 1, 0, 0, 1, 1, 0);
    // A greater / less ignore cascade
    step("gt_e", 2, 1, 0, 1, 0, 1, 0);
    step("gt_l", 2, 1, 1, 0, 0, 1, 0);
    step("gt_g", 2, 1, 0, 0, 1, 1, 0);
    step("lt_e", 1, 2, 0, 1, 0, 1, 0);
    step("lt_l", 1, 2, 1, 0, 0, 1, 0);
    step("lt_g", 1, 2, 0, 0, 1, 1, 0);
    // illegal cascade combinations and operand extremes
    step("all1", 7, 7, 1, 1, 1, 1, 0);
    step("l_g",  0, 0, 1, 0, 1, 1, 0);
    step("none", 5, 5, 0, 0, 0, 1, 0);
    step("max",  7, 0, 0, 1, 0, 1, 0);
    step("min",  0, 7, 0, 1, 0, 1, 0);
    // hold while in_valid is low
    step("hold0", 1, 2, 0, 1, 0, 1, 0);
    step("hold1", 6, 2, 0, 1, 0, 0, 0);
    check("hold_lt", {31'd0, lt}, 32'd1);
    step("hold2", 0, 3, 1, 0, 1, 0, 0);

    // randomized traffic, occasional reset and idle cycles
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, (1 << WIDTH) - 1),
           ($urandom_range(0, 3) == 0) ? 32'd3 : $urandom_range(0, (1 << WIDTH) - 1),
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_3bit.md
# comparator_3bit

Registered, cascadable magnitude comparator for two unsigned WIDTH-bit operands (3 bits by default). It produces one-hot less/equal/greater flags. Cascade inputs carry the verdict from a less-significant stage, so several instances can be chained into a wider comparator. The block sits in datapath compare logic and presents its result one clock after a valid input.

## Interface
- WIDTH, default 3: operand width in bits; legal range 1 to 32.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  unsigned operand A, more-significant slice of a chained compare.
- B  input  WIDTH  unsigned operand B.
- l  input  1  cascade-in: less-significant stage reports A<B.
- e  input  1  cascade-in: less-significant stage reports A==B; tie to 1 on the least-significant stage.
- g  input  1  cascade-in: less-significant stage reports A>B.
- in_valid  input  1  A, B, l, e and g are valid this cycle.
- lt  output  WIDTH-independent 1  registered result A<B.
- eq  output  1  registered result A==B.
- gt  output  1  registered result A>B.
- out_valid  output  1  lt/eq/gt hold the result of the previous valid input.

## Operation
- All magnitude comparisons are unsigned over WIDTH bits.
- If A>B: next gt=1, lt=0, eq=0. The cascade inputs are ignored.
- If A<B: next lt=1, gt=0, eq=0. The cascade inputs are ignored.
- If A==B, the result is resolved from the cascade inputs with fixed priority:
  - e=1 gives eq=1, regardless of l and g.
  - else l=1 gives lt=1, regardless of g.
  - else g=1 gives gt=1.
  - else (l=e=g=0) gives eq=1.
- When out_valid=1, exactly one of lt/eq/gt is 1. No cascade input combination breaks this.
- Chaining: connect a lower stage's lt/eq/gt to the upper stage's l/e/g. Each stage adds one cycle of latency, and the lower stage's output must be aligned with the upper stage's registered A/B by the user.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N with in_valid=1 appear on lt/eq/gt at edge N, and out_valid=1 after that edge.
- in_valid=0 at an edge: lt/eq/gt hold their previous values and out_valid goes to 0.
- Throughput is one compare per cycle. Back-to-back valid inputs update the outputs on every edge. There is no backpressure.
- rst=1 at an edge: lt=0, eq=0, gt=0, out_valid=0.
  - rst overrides in_valid.
  - An input presented in the same cycle as reset is discarded.
- First valid input after rst deasserts: the result appears one edge later, as normal.
- There is no combinational path from any input to any output.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1, A=2, B=1 -> lt=eq=gt=0 and out_valid=0 throughout. The first non-reset edge then yields gt=1, out_valid=1.
- Equal operands with cascade: A=1, B=1, in_valid=1, three consecutive cycles with (l,e,g) = (0,1,0), (1,0,0), (0,0,1) -> one cycle later, successive outputs eq=1, lt=1, gt=1, each one-hot, out_valid=1.
- A greater: A=2, B=1 with the same three cascade patterns -> gt=1, lt=0, eq=0 on all three results.
- A less: A=1, B=2 with the same three cascade patterns -> lt=1, gt=0, eq=0 on all three results.
- Illegal cascade and boundaries: A=B=7 with (l,e,g)=(1,1,1) -> eq=1; A=B=0 with (1,0,1) -> lt=1; A=B=5 with (0,0,0) -> eq=1. Also A=7, B=0 -> gt=1 and A=0, B=7 -> lt=1.
- Hold behaviour: after a valid A=1, B=2 (lt=1), drop in_valid and change A to 6 -> lt stays 1, out_valid=0.
